spectral_peak_finder: RTL
=========================

// Module: spectral_peak_finder
// PURPOSE
//  Parametrised successor to the 16-bin peak detector. Takes one complex FFT frame per handshake,
//  computes exact |X[k]|^2 per bin, and scans LANES bins/cycle for the argmax.
//  Returns peak bin index, peak magnitude and a below-threshold flag on a valid/ready output.
//  Sits between the FFT core and the frequency-report logic.
// PARAMETERS
//  NUM_BINS  16  bins per frame; power of 2, >=2
//  DW        16  signed width of each re/im component
//  LANES     4   bins compared per scan cycle; power of 2, divides NUM_BINS
// PORTS
//  clk          in   1               single clock, rising edge
//  rst          in   1               asynchronous, active-low reset
//  in_valid     in   1               frame on in_data is valid
//  in_ready     out  1               block can accept a frame
//  in_data      in   NUM_BINS*2*DW   bin k at [k*2*DW +: 2*DW]; re in upper DW bits, im in lower; two's complement
//  thresh       in   2*DW            minimum peak magnitude; sampled at frame accept
//  out_valid    out  1               result valid
//  out_ready    in   1               consumer takes the result
//  peak_idx     out  log2(NUM_BINS)  winning bin index
//  peak_mag     out  2*DW            unsigned re^2+im^2 of the winning bin
//  no_peak      out  1               peak_mag < sampled thresh
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, in_ready=1, out_valid=0, peak_idx=0, peak_mag=0, no_peak=0, scan counter=0.
//  - Magnitude: unsigned 2*DW bits, exact, no truncation.
//    Worst case (-2^(DW-1))^2 * 2 = 2^(2*DW-1) fits.
//  - FSM IDLE -> SCAN -> DONE -> IDLE.
//    IDLE:  in_ready=1. On in_valid&&in_ready: register in_data and thresh, clear best, counter=0, go SCAN.
//    SCAN:  in_ready=0. Each cycle, compare bins [cnt*LANES +: LANES] against the running best; cnt++.
//           After NUM_BINS/LANES cycles, go DONE.
//    DONE:  out_valid=1; peak_idx, peak_mag and no_peak are stable while out_ready=0.
//           On out_valid&&out_ready: go IDLE, out_valid=0 next cycle.
//  - Latency: accept at cycle 0, out_valid at cycle NUM_BINS/LANES+1. Throughput is one frame per NUM_BINS/LANES+2 cycles minimum.
//  - Compare key is {mag, idx}; larger key wins. Equal magnitudes: the highest index wins.
//    All-zero frame gives idx=NUM_BINS-1, mag=0.
//  - The running best resets to key 0 at accept, so bin 0 with mag 0 can be overwritten by any later bin.
//  - in_valid while not in IDLE is ignored; the frame is held by the producer, not dropped by this block.
//  - no_peak = (peak_mag < thresh_q). Registered together with peak_mag on the SCAN->DONE edge.
//  - Reset mid-SCAN or mid-DONE aborts the frame. No partial result is ever presented.
//  - Outputs other than out_valid keep their last values in IDLE.
// CONFIGURATION
//  SPF_SKIP_DC_EN defined:   bin 0 is never a candidate; its key is forced to 0 during scan.
//                            An all-zero frame still gives idx=NUM_BINS-1.
//  SPF_SKIP_DC_EN undefined: all bins 0..NUM_BINS-1 are candidates.
// STRUCTURE
//  - Package spf_pkg: state enum {IDLE,SCAN,DONE}; localparams IDXW=$clog2(NUM_BINS), MW=2*DW,
//    SCAN_CYC=NUM_BINS/LANES; function mag_sq(re,im).
//  - Sub-module spf_lane_argmax: combinational LANES-wide {mag,idx} compare tree plus the running-best input.
//    It is instantiated once. The top level holds the FSM, frame register, counter and output registers.
// TESTING (NUM_BINS=16, DW=16, LANES=4 unless noted)
//  1. Bin 5 re=1000 im=0, others 0, thresh=0 -> out_valid 5 cycles after accept; idx=5, mag=1000000, no_peak=0.
//  2. Bins 3 and 9 both re=300 im=-400, others 0 -> idx=9, mag=250000 (tie goes to the higher index).
//  3. Bin 15 re=im=-32768, bin 0 re=32767 -> idx=15, mag=0x80000000 (no overflow).
//  4. out_ready low for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored.
//     Then out_ready=1 -> in_ready=1 the next cycle and the next frame is accepted.
//  5. All bins re=10 im=10, thresh=0x1000 -> idx=15, mag=200, no_peak=1.
//  6. Assert rst in the 2nd SCAN cycle -> all outputs reset immediately.
//     After release, in_ready=1 and a fresh frame gives the correct result.
//  7. SPF_SKIP_DC_EN with bin0 re=20000 and bin 7 re=100 -> idx=7. Without the macro -> idx=0.
//  8. LANES=1 and LANES=16 builds, rerunning scenario 1 -> out_valid 17 cycles and 2 cycles after accept.

Source files
------------

// File: rtl/spf_pkg.sv
// Shared types and helpers for the spectral peak finder.
package spf_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  // Widest component the magnitude helper supports; callers take the low 2*DW bits.
  localparam int MAX_DW = 32;

  function automatic logic [2*MAX_DW-1:0] mag_sq(input logic signed [MAX_DW-1:0] re,
                                                 input logic signed [MAX_DW-1:0] im);
    logic signed [2*MAX_DW-1:0] re_sq;
    logic signed [2*MAX_DW-1:0] im_sq;
    re_sq = re * re;
    im_sq = im * im;
    return $unsigned(re_sq) + $unsigned(im_sq);
  endfunction

endpackage

// File: rtl/spf_lane_argmax.sv
// Combinational argmax of LANES bins against the running best, keyed on {mag, idx}.
// With SPF_SKIP_DC_EN defined, bin 0 is forced to key 0 and never wins.
module spf_lane_argmax
  import spf_pkg::*;
#(
  parameter int NUM_BINS = 16,
  parameter int DW       = 16,
  parameter int LANES    = 4,
  parameter int IDXW     = $clog2(NUM_BINS),
  parameter int MW       = 2 * DW
) (
  input  logic [LANES*2*DW-1:0] lane_data,
  input  logic [IDXW-1:0]       base_idx,
  input  logic [MW-1:0]         best_mag_in,
  input  logic [IDXW-1:0]       best_idx_in,
  output logic [MW-1:0]         best_mag_out,
  output logic [IDXW-1:0]       best_idx_out
);

  logic signed [DW-1:0] re;
  logic signed [DW-1:0] im;
  logic [MW-1:0]        mag;
  logic [IDXW-1:0]      idx;

  // Bins arrive in ascending index order, so a strict key compare lets ties go to the later bin.
  always_comb begin
    best_mag_out = best_mag_in;
    best_idx_out = best_idx_in;
    re  = '0;
    im  = '0;
    mag = '0;
    idx = '0;
    for (int i = 0; i < LANES; i++) begin
      re  = lane_data[i*2*DW+DW +: DW];
      im  = lane_data[i*2*DW +: DW];
      idx = base_idx + IDXW'(i);
      mag = MW'(mag_sq(MAX_DW'(re), MAX_DW'(im)));
`ifdef SPF_SKIP_DC_EN
      if (idx == '0) mag = '0;
`endif
      if ({mag, idx} > {best_mag_out, best_idx_out}) begin
        best_mag_out = mag;
        best_idx_out = idx;
      end
    end
  end

endmodule

// File: rtl/spectral_peak_finder.sv
// Accepts one complex FFT frame, scans LANES bins per cycle for the peak |X[k]|^2 and reports it.
// Optional SPF_SKIP_DC_EN excludes bin 0 from the search.
module spectral_peak_finder
  import spf_pkg::*;
#(
  parameter int NUM_BINS = 16,
  parameter int DW       = 16,
  parameter int LANES    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_BINS*2*DW-1:0]    in_data,
  input  logic [2*DW-1:0]             thresh,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NUM_BINS)-1:0] peak_idx,
  output logic [2*DW-1:0]             peak_mag,
  output logic                        no_peak
);

  localparam int IDXW     = $clog2(NUM_BINS);
  localparam int MW       = 2 * DW;
  localparam int SCAN_CYC = NUM_BINS / LANES;
  localparam int CNTW     = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int LW       = LANES * 2 * DW;

  state_e                   state_q, state_d;
  logic [NUM_BINS*2*DW-1:0] frame_q, frame_d;
  logic [MW-1:0]            thresh_q, thresh_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [MW-1:0]            best_mag_q, best_mag_d;
  logic [IDXW-1:0]          best_idx_q, best_idx_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [IDXW-1:0]          peak_idx_q, peak_idx_d;
  logic [MW-1:0]            peak_mag_q, peak_mag_d;
  logic                     no_peak_q, no_peak_d;

  logic [LW-1:0]   lane_data;
  logic [IDXW-1:0] base_idx;
  logic [MW-1:0]   lane_mag;
  logic [IDXW-1:0] lane_idx;

  assign lane_data = frame_q[int'(cnt_q)*LW +: LW];
  assign base_idx  = IDXW'(int'(cnt_q) * LANES);

  spf_lane_argmax #(
    .NUM_BINS (NUM_BINS),
    .DW       (DW),
    .LANES    (LANES),
    .IDXW     (IDXW),
    .MW       (MW)
  ) u_lane_argmax (
    .lane_data    (lane_data),
    .base_idx     (base_idx),
    .best_mag_in  (best_mag_q),
    .best_idx_in  (best_idx_q),
    .best_mag_out (lane_mag),
    .best_idx_out (lane_idx)
  );

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    thresh_d    = thresh_q;
    cnt_d       = cnt_q;
    best_mag_d  = best_mag_q;
    best_idx_d  = best_idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    peak_idx_d  = peak_idx_q;
    peak_mag_d  = peak_mag_q;
    no_peak_d   = no_peak_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          frame_d    = in_data;
          thresh_d   = thresh;
          best_mag_d = '0;
          best_idx_d = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        best_mag_d = lane_mag;
        best_idx_d = lane_idx;
        cnt_d      = cnt_q + CNTW'(1);
        // Results are captured straight from the last lane pass so DONE never shows a partial best.
        if (cnt_q == CNTW'(SCAN_CYC - 1)) begin
          cnt_d       = '0;
          peak_idx_d  = lane_idx;
          peak_mag_d  = lane_mag;
          no_peak_d   = (lane_mag < thresh_q);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      thresh_q    <= '0;
      cnt_q       <= '0;
      best_mag_q  <= '0;
      best_idx_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      peak_idx_q  <= '0;
      peak_mag_q  <= '0;
      no_peak_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      thresh_q    <= thresh_d;
      cnt_q       <= cnt_d;
      best_mag_q  <= best_mag_d;
      best_idx_q  <= best_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      peak_idx_q  <= peak_idx_d;
      peak_mag_q  <= peak_mag_d;
      no_peak_q   <= no_peak_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign peak_idx  = peak_idx_q;
  assign peak_mag  = peak_mag_q;
  assign no_peak   = no_peak_q;

endmodule
